// File: rtl/syncres_chk_pkg.sv
// Shared definitions for the sync-reset flop response checker: state encoding and
// an all-ones constant helper used for saturation and "no failure" markers.
package syncres_chk_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WARM  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StWarm  = ST_WARM,
    StCheck = ST_CHECK,
    StDone  = ST_DONE
  } state_e;

  // Low 'width' bits set; callers cast down to their own width.
  function automatic logic [31:0] ALL_ONES(input int unsigned width);
    if (width >= 32) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/syncres_ref_model.sv
// LATENCY-deep expected-value pipeline: an ideal sync-reset flop followed by
// LATENCY-1 plain delay stages, updated every non-reset cycle.
module syncres_ref_model
  import syncres_chk_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic dut_rst,
  input  logic dut_d,
  output logic exp_q
);

  logic               in_bit;
  logic [LATENCY-1:0] pipe_q, pipe_d;

  assign in_bit = dut_rst ? 1'b0 : dut_d;

  if (LATENCY == 1) begin : g_one
    assign pipe_d = in_bit;
  end else begin : g_deep
    assign pipe_d = {pipe_q[LATENCY-2:0], in_bit};
  end

  always_ff @(posedge clk) begin
    if (sync_reset) pipe_q <= '0;
    else            pipe_q <= pipe_d;
  end

  assign exp_q = pipe_q[LATENCY-1];

endmodule

// File: rtl/syncres_resp_checker.sv
// Response checker for a sync-reset D flop: warms up the expected pipe after start,
// then compares dut_q against it for WINDOW cycles and holds the results.
module syncres_resp_checker
  import syncres_chk_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned WINDOW  = 128,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned CYC_W   = 16
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             start,
  input  logic             dut_rst,
  input  logic             dut_d,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CYC_W-1:0] first_err_cyc,
  output logic [CYC_W-1:0] cyc_cnt
);

  localparam logic [CNT_W-1:0] CntMax   = CNT_W'(ALL_ONES(CNT_W));
  localparam logic [CYC_W-1:0] CycNone  = CYC_W'(ALL_ONES(CYC_W));
  localparam logic [CYC_W-1:0] CycLast  = CYC_W'(WINDOW - 1);
  localparam int unsigned      WarmW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WarmW-1:0] WarmLast = WarmW'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [WarmW-1:0] warm_q, warm_d;
  logic [CYC_W-1:0] cyc_q, cyc_d, first_q, first_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             exp_bit, mismatch;

  syncres_ref_model #(
    .LATENCY (LATENCY)
  ) u_ref (
    .clk        (clk),
    .sync_reset (sync_reset),
    .dut_rst    (dut_rst),
    .dut_d      (dut_d),
    .exp_q      (exp_bit)
  );

  assign mismatch = dut_q ^ exp_bit;

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    first_d = first_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWarm;
          warm_d  = '0;
          cyc_d   = '0;
          err_d   = '0;
          first_d = CycNone;
        end
      end
      StWarm: begin
        if (warm_q == WarmLast) state_d = StCheck;
        else                    warm_d  = warm_q + WarmW'(1);
      end
      StCheck: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (mismatch) begin
          if (err_q != CntMax)    err_d   = err_q + CNT_W'(1);
          if (first_q == CycNone) first_d = cyc_q;
        end
        if (cyc_q == CycLast) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    // Outputs are registered from the next state so they never see dut_* combinationally.
    busy_d = (state_d == StWarm) || (state_d == StCheck);
    done_d = (state_d == StDone);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= StIdle;
      warm_q  <= '0;
      cyc_q   <= '0;
      err_q   <= '0;
      first_q <= CycNone;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign first_err_cyc = first_q;
  assign cyc_cnt       = cyc_q;

endmodule

// File: tb/tb_syncres_resp_checker.sv
// Randomized scoreboard bench: four checker instances (latency 1/2, narrow counter)
// watch behavioural 1- and 2-stage flop DUTs; expected run results are queued at issue.
module tb_syncres_resp_checker;

  localparam int W = 128;
  localparam int N = W + 4;

  typedef struct {
    int err0;
    int first0;
    int err1;
    int err3;
    int done_at;
  } exp_t;

  logic clk = 1'b0;
  logic sync_reset = 1'b1, start = 1'b0, dut_rst = 1'b0, dut_d = 1'b0, inject = 1'b0;
  logic q1 = 1'b0, q2a = 1'b0, q2b = 1'b0;
  logic dq1, dq2;
  int   edge_n = 0;
  int   checks = 0, errors = 0;
  logic mon_prev = 1'b0;
  exp_t sb[$];
  bit   rst_p[N], d_p[N], flt_p[N], st_p[N];

  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic        busy2, done2, pass2, busy3, done3, pass3;
  logic [7:0]  err0, err2, err3;
  logic [3:0]  err1;
  logic [15:0] first0, cyc0, first1, cyc1, first2, cyc2, first3, cyc3;

  always #10 clk = ~clk;

  // Behavioural DUTs: ideal single flop (with fault injection) and a two-stage variant.
  always @(posedge clk) begin
    q1     <= dut_rst ? 1'b0 : dut_d;
    q2a    <= dut_rst ? 1'b0 : dut_d;
    q2b    <= q2a;
    edge_n <= edge_n + 1;
  end
  assign dq1 = q1 ^ inject;
  assign dq2 = q2b;

  syncres_resp_checker #(.LATENCY(1), .WINDOW(W), .CNT_W(8), .CYC_W(16)) u0 (
    .clk(clk), .sync_reset(sync_reset), .start(start), .dut_rst(dut_rst), .dut_d(dut_d),
    .dut_q(dq1), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_err_cyc(first0), .cyc_cnt(cyc0));
  syncres_resp_checker #(.LATENCY(1), .WINDOW(W), .CNT_W(4), .CYC_W(16)) u1 (
    .clk(clk), .sync_reset(sync_reset), .start(start), .dut_rst(dut_rst), .dut_d(dut_d),
    .dut_q(dq1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_cyc(first1), .cyc_cnt(cyc1));
  syncres_resp_checker #(.LATENCY(2), .WINDOW(W), .CNT_W(8), .CYC_W(16)) u2 (
    .clk(clk), .sync_reset(sync_reset), .start(start), .dut_rst(dut_rst), .dut_d(dut_d),
    .dut_q(dq2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .first_err_cyc(first2), .cyc_cnt(cyc2));
  syncres_resp_checker #(.LATENCY(1), .WINDOW(W), .CNT_W(8), .CYC_W(16)) u3 (
    .clk(clk), .sync_reset(sync_reset), .start(start), .dut_rst(dut_rst), .dut_d(dut_d),
    .dut_q(dq2), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .first_err_cyc(first3), .cyc_cnt(cyc3));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Value an ideal sync-reset flop loads at planned step t.
  function automatic bit f(input int t);
    return rst_p[t] ? 1'b0 : d_p[t];
  endfunction

  // Step t is the edge k+t (start sampled at k). A latency-L checker compares at step L+1+j.
  function automatic exp_t model();
    exp_t e;
    e.err0 = 0; e.first0 = 65535; e.err1 = 0; e.err3 = 0; e.done_at = 0;
    for (int j = 0; j < W; j++) begin
      int t = j + 2;
      if ((f(t - 1) ^ flt_p[t]) != f(t - 1)) begin
        if (e.first0 == 65535) e.first0 = j;
        if (e.err0 < 255) e.err0++;
        if (e.err1 < 15) e.err1++;
      end
      // Two-stage DUT holds f(t-2) while a latency-1 checker expects f(t-1).
      if (f(t - 2) != f(t - 1) && e.err3 < 255) e.err3++;
    end
    return e;
  endfunction

  task automatic plan(input int mode);
    for (int t = 0; t < N; t++) begin
      rst_p[t] = ($urandom_range(7) == 0);
      d_p[t]   = 1'($urandom_range(1));
      flt_p[t] = 1'b0;
      st_p[t]  = 1'b0;
      if (mode == 2) begin
        rst_p[t] = 1'b1; d_p[t] = 1'b1; flt_p[t] = 1'b1;
      end
      if (mode == 3) flt_p[t] = ($urandom_range(15) == 0);
    end
    if (mode == 1) flt_p[39] = 1'b1;
    if (mode == 3) st_p[W / 2] = 1'b1;
  endtask

  task automatic run(input bit push, input int abort_t);
    exp_t e;
    if (push) begin
      e = model();
      e.done_at = edge_n + 1 + 2 + W;
      sb.push_back(e);
    end
    for (int t = 0; t < N; t++) begin
      start      = (t == 0) || st_p[t];
      dut_rst    = rst_p[t];
      dut_d      = d_p[t];
      inject     = flt_p[t];
      sync_reset = (t == abort_t);
      @(posedge clk); #1;
      if (t == abort_t) begin
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_err", err0, 0);
        chk("abort_cyc", cyc0, 0);
        chk("abort_first", first0, 65535);
        chk("abort_busy2", busy2, 0);
        break;
      end
      if (t == 0) begin
        chk("start_busy", busy0, 1);
        chk("start_cyc", cyc0, 0);
        chk("start_err", err0, 0);
        chk("start_first", first0, 65535);
      end
      if (t == W) chk("done_early", done0, 0);
      if (t == W + 1) begin
        chk("done_on_time", done0, 1);
        chk("idle_busy", busy0, 0);
      end
    end
    start = 1'b0; sync_reset = 1'b0; inject = 1'b0;
  endtask

  // Monitor: pops one expectation per completed run (latency-2 instance finishes last).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done2 && !mon_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_at", edge_n, e.done_at);
          chk("err0", err0, e.err0);
          chk("first0", first0, e.first0);
          chk("cyc0", cyc0, W);
          chk("pass0", pass0, e.err0 == 0);
          chk("err1_sat", err1, e.err1);
          chk("first1", first1, e.first0);
          chk("err2", err2, 0);
          chk("pass2", pass2, 1);
          chk("cyc2", cyc2, W);
          chk("err3", err3, e.err3);
          chk("pass3", pass3, e.err3 == 0);
        end
      end
      mon_prev = done2;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at edge %0d", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_cyc", cyc0, 0);
    chk("rst_first", first0, 65535);
    sync_reset = 1'b0;
    @(posedge clk); #1;

    plan(0); run(1, -1);                 // clean
    plan(1); run(1, -1);                 // single fault at compare 37
    plan(2); run(1, -1);                 // reset priority, every compare fails
    for (int i = 0; i < 3; i++) begin    // random faults, start pulsed mid-check
      plan(3); run(1, -1);
    end

    // start together with sync_reset from DONE: reset wins
    start = 1'b1; sync_reset = 1'b1;
    @(posedge clk); #1;
    chk("sr_busy", busy0, 0);
    chk("sr_done", done0, 0);
    start = 1'b0; sync_reset = 1'b0;
    @(posedge clk); #1;
    chk("sr_stay_idle", busy0, 0);

    plan(3); run(1, -1);                 // run from IDLE
    plan(3); run(0, 52);                 // reset at compare index 50
    @(posedge clk); #1;
    chk("post_abort_busy", busy0, 0);
    plan(0); run(1, -1);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
